// File: rtl/line_mem_responder.sv
// Line memory responder: DEPTH x LINE_W array serving whole-line refills and write-backs.
// Latency: LATENCY busy cycles per access; a refill's ready pulse comes the cycle after the last busy cycle.
// Backpressure: mem_wait=1 while busy; requests are only sampled in IDLE and are ignored otherwise, including during the ready cycle.
// Optional feature: define MEM_BOUNDS_CHECK_EN to add mem_err and range-check the full mem_addr[31:4].
module line_mem_responder #(
  parameter int LINE_W   = 128,
  parameter int IDX_BITS = 10,
  parameter int LATENCY  = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              mem_read,
  input  logic              mem_write,
  input  logic [31:0]       mem_addr,
  input  logic [LINE_W-1:0] mem_write_data,
  output logic [LINE_W-1:0] mem_read_data,
  output logic              mem_read_data_ready,
  output logic              mem_wait
`ifdef MEM_BOUNDS_CHECK_EN
  ,
  output logic              mem_err
`endif
);

  localparam int DEPTH = 2 ** IDX_BITS;
  localparam int CNT_W = (LATENCY > 1) ? $clog2(LATENCY) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(LATENCY - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WR   = 2'd1,
    S_RD   = 2'd2,
    S_RESP = 2'd3
  } state_e;

  // Line storage; deliberately has no reset so contents survive rst.
  logic [LINE_W-1:0] mem_q [DEPTH];

  state_e              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                pend_rd_q, pend_rd_d;
  logic [IDX_BITS-1:0] idx_q, idx_d;
  logic [LINE_W-1:0]   wdata_q, wdata_d;
  logic [LINE_W-1:0]   rdata_q;
  logic                wr_done;
  logic                rd_load;
  logic                mem_we;
  logic [IDX_BITS-1:0] addr_idx;

  assign addr_idx = mem_addr[IDX_BITS+3:4];

`ifdef MEM_BOUNDS_CHECK_EN
  logic oob_q, oob_d;
  logic err_q;
  logic addr_oob;
  logic [3:0] unused_addr_bits;

  // Any set bit above the index field means the line lies beyond the array.
  assign addr_oob         = |mem_addr[31:IDX_BITS+4];
  assign unused_addr_bits = mem_addr[3:0];
  assign mem_we           = wr_done & ~oob_q;
  assign mem_err          = err_q;
`else
  logic [31-IDX_BITS:0] unused_addr_bits;

  // Byte offset and upper address bits are ignored: the index wraps mod DEPTH.
  assign unused_addr_bits = {mem_addr[31:IDX_BITS+4], mem_addr[3:0]};
  assign mem_we           = wr_done;
`endif

  assign mem_wait            = (state_q == S_WR) || (state_q == S_RD);
  assign mem_read_data_ready = (state_q == S_RESP);
  assign mem_read_data       = rdata_q;

  // Next-state logic: accept in IDLE, count busy cycles, chain write-then-read.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    pend_rd_d = pend_rd_q;
    idx_d     = idx_q;
    wdata_d   = wdata_q;
    wr_done   = 1'b0;
    rd_load   = 1'b0;
`ifdef MEM_BOUNDS_CHECK_EN
    oob_d     = oob_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (mem_write) begin
          // Write wins a simultaneous read; the read replays on the same line afterwards.
          idx_d     = addr_idx;
          wdata_d   = mem_write_data;
          pend_rd_d = mem_read;
          cnt_d     = '0;
          state_d   = S_WR;
`ifdef MEM_BOUNDS_CHECK_EN
          oob_d     = addr_oob;
`endif
        end else if (mem_read) begin
          idx_d   = addr_idx;
          cnt_d   = '0;
          state_d = S_RD;
`ifdef MEM_BOUNDS_CHECK_EN
          oob_d   = addr_oob;
`endif
        end
      end
      S_WR: begin
        if (cnt_q == CNT_LAST) begin
          wr_done = 1'b1;
          cnt_d   = '0;
          if (pend_rd_q) begin
            pend_rd_d = 1'b0;
            state_d   = S_RD;
          end else begin
            state_d = S_IDLE;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_RD: begin
        if (cnt_q == CNT_LAST) begin
          rd_load = 1'b1;
          cnt_d   = '0;
          state_d = S_RESP;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_RESP: begin
        // Ready cycle: nothing is accepted here.
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Control and latched-request registers; rst aborts any access in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      pend_rd_q <= 1'b0;
      idx_q     <= '0;
      wdata_q   <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      pend_rd_q <= pend_rd_d;
      idx_q     <= idx_d;
      wdata_q   <= wdata_d;
    end
  end

  // Array write on the last WR cycle; gated by rst so an aborted write never lands.
  always_ff @(posedge clk) begin
    if (mem_we && !rst) begin
      mem_q[idx_q] <= wdata_q;
    end
  end

  // Refill register: loaded on the last RD cycle, held until the next refill.
  always_ff @(posedge clk) begin
    if (rst) begin
      rdata_q <= '0;
`ifdef MEM_BOUNDS_CHECK_EN
    end else if (rd_load) begin
      rdata_q <= oob_q ? '0 : mem_q[idx_q];
`else
    end else if (rd_load) begin
      rdata_q <= mem_q[idx_q];
`endif
    end
  end

`ifdef MEM_BOUNDS_CHECK_EN
  // Out-of-range flag for the current access, and the error pulse it raises on completion.
  always_ff @(posedge clk) begin
    if (rst) begin
      oob_q <= 1'b0;
      err_q <= 1'b0;
    end else begin
      oob_q <= oob_d;
      err_q <= oob_q & (wr_done | rd_load);
    end
  end
`endif

endmodule
